pc_ctrl: RTL

Next-PC controller for the pipelined RISC-V core's fetch stage. Owns the fetch program counter and selects each cycle between sequential advance, hold (hazard stall or instruction memory not ready), branch/jump redirect from EX, and trap redirect. Generates the IF/ID and ID/EX flush strobes, a halt/resume mode for debug, and a saturating redirect counter for performance visibility.

---
 rtl/pc_ctrl_pkg.sv | 18 +
 rtl/sat_counter.sv | 35 +++
 rtl/pc_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the fetch-stage next-PC controller.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam logic [31:0] PC_STEP              = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: advances on inc and sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count, held once the all-ones ceiling is reached
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pc_ctrl.sv
// Fetch program counter owner: sequential advance, hold, branch/trap redirect,
// pipeline flush strobes, debug halt/resume and a redirect performance counter.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             br_taken_i,
  input  logic [31:0]      br_target_i,
  input  logic             trap_i,
  input  logic             halt_i,
  input  logic             resume_i,
  input  logic             imem_ready_i,
  output logic [31:0]      pc_out,
  output logic             fetch_valid_o,
  output logic             flush_ifid_o,
  output logic             flush_idex_o,
  output logic             misalign_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);

  state_e      state_q;
  state_e      state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        fetch_valid_q;
  logic        redirect_s;
  logic        misalign_s;

  // Next-state and next-PC selection; redirects outrank stall and not-ready
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect_s = 1'b0;
    misalign_s = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (trap_i) begin
          redirect_s = 1'b1;
          pc_d       = TRAP_VECTOR;
        end else if (br_taken_i) begin
          redirect_s = 1'b1;
          if (is_misaligned(br_target_i)) begin
            misalign_s = 1'b1;
            pc_d       = TRAP_VECTOR;
          end else begin
            pc_d       = br_target_i;
          end
        end else if (stall_i || !imem_ready_i) begin
          pc_d = pc_q;
        end else begin
          pc_d = pc_q + PC_STEP;
        end
        // A redirect in the halting cycle still lands; halt takes effect after it
        if (halt_i) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        if (resume_i) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: begin
        state_d = ST_BOOT;
        pc_d    = RESET_VECTOR;
      end
    endcase
  end

  // State, PC and fetch-valid registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_VECTOR;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= (state_d == ST_RUN);
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_redirect_cnt (
    .clk (clk),
    .rst (rst),
    .inc (redirect_s),
    .cnt (redirect_cnt_o)
  );

  assign pc_out        = pc_q;
  assign fetch_valid_o = fetch_valid_q;
  assign flush_ifid_o  = redirect_s;
  assign flush_idex_o  = redirect_s;
  assign misalign_o    = misalign_s;

endmodule
